// File: rtl/vga_sync_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_sync_gen
// Description : VGA raster timing. Wrapping x/y counters advanced by pix_en,
//               registered sync/blank decode and line/frame start pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_sync_gen #(
  parameter int H_VIS    = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_VIS    = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0,
  parameter int CW       = 10
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          pix_en,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic [CW-1:0] pixel_x,
  output logic [CW-1:0] pixel_y,
  output logic          line_start,
  output logic          frame_start
);

  localparam int            c_H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int            c_V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam logic [CW-1:0] c_X_MAX   = CW'(c_H_TOTAL - 1);
  localparam logic [CW-1:0] c_Y_MAX   = CW'(c_V_TOTAL - 1);
  localparam logic [CW-1:0] c_HS_ON   = CW'(H_VIS + H_FP);
  localparam logic [CW-1:0] c_HS_OFF  = CW'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] c_VS_ON   = CW'(V_VIS + V_FP);
  localparam logic [CW-1:0] c_VS_OFF  = CW'(V_VIS + V_FP + V_SYNC - 1);
  localparam logic [CW-1:0] c_X_VIS   = CW'(H_VIS);
  localparam logic [CW-1:0] c_Y_VIS   = CW'(V_VIS);
  localparam logic [CW-1:0] c_ONE     = CW'(1);

  logic [CW-1:0] r_x;
  logic [CW-1:0] r_y;
  logic          r_hsync;
  logic          r_vsync;
  logic          r_video_on;
  logic          r_line_start;
  logic          r_frame_start;

  logic          w_x_wrap;
  logic          w_y_wrap;
  logic [CW-1:0] w_x_nxt;
  logic [CW-1:0] w_y_nxt;
  logic          w_hs_act;
  logic          w_vs_act;
  logic          w_vis_nxt;

  assign w_x_wrap = (r_x == c_X_MAX);
  assign w_y_wrap = (r_y == c_Y_MAX);

  always_comb begin
    w_x_nxt = r_x;
    w_y_nxt = r_y;
    if (pix_en) begin
      w_x_nxt = w_x_wrap ? '0 : r_x + c_ONE;
      if (w_x_wrap) begin
        w_y_nxt = w_y_wrap ? '0 : r_y + c_ONE;
      end
    end
  end

  // Decode from the next counter values so levels switch with the counters.
  assign w_hs_act  = (w_x_nxt >= c_HS_ON) && (w_x_nxt <= c_HS_OFF);
  assign w_vs_act  = (w_y_nxt >= c_VS_ON) && (w_y_nxt <= c_VS_OFF);
  assign w_vis_nxt = (w_x_nxt < c_X_VIS) && (w_y_nxt < c_Y_VIS);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_x           <= c_X_MAX;
      r_y           <= c_Y_MAX;
      r_hsync       <= ~SYNC_POL;
      r_vsync       <= ~SYNC_POL;
      r_video_on    <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_x           <= w_x_nxt;
      r_y           <= w_y_nxt;
      r_hsync       <= w_hs_act ? SYNC_POL : ~SYNC_POL;
      r_vsync       <= w_vs_act ? SYNC_POL : ~SYNC_POL;
      r_video_on    <= w_vis_nxt;
      r_line_start  <= pix_en && w_x_wrap;
      r_frame_start <= pix_en && w_x_wrap && w_y_wrap;
    end
  end

  assign pixel_x     = r_x;
  assign pixel_y     = r_y;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign video_on    = r_video_on;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;

endmodule
`default_nettype wire
